stepgen_ramp: RTL

- Acceleration-limited velocity stage sitting directly upstream of the stepgen; its output drives the stepgen velocity input.
- Holds a target velocity latched from the SPI register file.
- Slews the output velocity toward that target by at most `accel` per ramp tick.
- Forces a one-tick zero dwell at every sign reversal, so stepgen sees a clean direction change.

---
 rtl/stepgen_ramp.sv | 130 +++++++++++++
 1 files changed

// File: rtl/stepgen_ramp.sv
// Acceleration-limited velocity stage feeding the stepgen velocity input.
// Slews velocity toward the effective target by at most accel per ramp tick, with a zero dwell on reversal.
module stepgen_ramp #(
    parameter int F = 10,
    parameter int A = 8,
    parameter int D = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                load,
    input  logic signed [F:0]   target_in,
    input  logic        [A-1:0] accel,
    input  logic        [D-1:0] ramp_div,
    output logic signed [F:0]   velocity,
    output logic                at_target,
    output logic                stopped
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_UP,
        ST_DOWN
    } state_t;

    localparam logic signed [F:0] V_MIN   = {1'b1, {F{1'b0}}};
    localparam logic signed [F:0] V_FLOOR = {1'b1, {(F-1){1'b0}}, 1'b1};

    logic signed [F:0]   r_velocity;
    logic signed [F:0]   r_target;
    logic        [D-1:0] r_cnt;
    logic                r_at_target;
    logic                r_stopped;

    logic                w_tick;
    logic signed [F:0]   w_tgt;
    logic signed [F:0]   w_target_load;
    state_t              w_state;
    logic signed [F+1:0] w_vel_ext;
    logic signed [F+1:0] w_tgt_ext;
    logic signed [F+1:0] w_accel_ext;
    logic signed [F+1:0] w_sum;
    logic                w_over;
    logic signed [F:0]   w_nxt;
    logic signed [F:0]   w_vel_next;

    assign w_tick        = (r_cnt == '0);
    assign w_tgt         = enable ? r_target : '0;
    assign w_target_load = (target_in == V_MIN) ? V_FLOOR : target_in;

    // Sums are carried one bit wider so velocity +/- accel cannot wrap before the clamp.
    assign w_vel_ext   = {r_velocity[F], r_velocity};
    assign w_tgt_ext   = {w_tgt[F], w_tgt};
    assign w_accel_ext = signed'({{(F+2-A){1'b0}}, accel});

    always_comb begin
        w_state = ST_HOLD;
        if (r_velocity < w_tgt) begin
            w_state = ST_UP;
        end else if (r_velocity > w_tgt) begin
            w_state = ST_DOWN;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_sum  = w_vel_ext;
        w_over = 1'b0;
        unique case (w_state)
            ST_UP: begin
                w_sum  = w_vel_ext + w_accel_ext;
                w_over = (w_sum > w_tgt_ext);
            end
            ST_DOWN: begin
                w_sum  = w_vel_ext - w_accel_ext;
                w_over = (w_sum < w_tgt_ext);
            end
            default: begin
                w_sum  = w_vel_ext;
                w_over = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_nxt = w_over ? w_tgt : w_sum[F:0];
        // A step that would cross zero lands on zero for one tick so stepgen sees a clean direction change.
        if ((r_velocity != '0) && (w_nxt[F] != r_velocity[F]) && (w_nxt != '0)) begin
            w_nxt = '0;
        end
        w_vel_next = w_tick ? w_nxt : r_velocity;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= ramp_div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
        end else if (load) begin
            r_target <= w_target_load;
        end
    end

    // Status flags are computed from the next velocity so they change on the same edge as velocity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_velocity  <= '0;
            r_at_target <= 1'b1;
            r_stopped   <= 1'b1;
        end else begin
            r_velocity  <= w_vel_next;
            r_at_target <= (w_vel_next == w_tgt);
            r_stopped   <= (w_vel_next == '0);
        end
    end

    assign velocity  = r_velocity;
    assign at_target = r_at_target;
    assign stopped   = r_stopped;

endmodule
